conv_row_feeder: RTL and testbench

// - Upstream feeder for the 3x3 weight-stationary PE array: reads image from banked on-chip memory and streams

---
 rtl/cnn_pkg.sv | 14 +
 rtl/feeder_addr_gen.sv | 58 +++++
 rtl/conv_row_feeder.sv | 129 ++++++++++++
 tb/tb_conv_row_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN feeder constants and feeder FSM state encoding
//   DATA_W      pixel width (Q1.6 signed, passed through untouched)
//   IMG_WIDTH   square image side in pixels
//   KERNEL      kernel side = output lanes = memory banks
//   ADDR_W      memory address width
//   DRAIN_BEATS zero beats appended after the last row
package cnn_pkg;
    localparam int DATA_W      = 8;
    localparam int IMG_WIDTH   = 5;
    localparam int KERNEL      = 3;
    localparam int ADDR_W      = 5;
    localparam int DRAIN_BEATS = 3;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} feeder_state_e;
endpackage

// File: rtl/feeder_addr_gen.sv
// feeder_addr_gen: row/beat counters and per-lane skewed addresses with pad flags
//   sys_clk    in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   step       in   advance to the next beat (one issued beat per step)
//   addr       out  lane m address in [m*ADDR_W +: ADDR_W], 0 when padded
//   pad        out  lane m lies outside the image row at this beat
//   row_first  out  current beat is p==0
//   row_last   out  current beat is p==BEATS-1
//   frame_last out  current beat is the final beat of the frame
module feeder_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH = cnn_pkg::IMG_WIDTH,
    parameter int KERNEL    = cnn_pkg::KERNEL,
    parameter int ADDR_W    = cnn_pkg::ADDR_W
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     step,
    output logic [KERNEL*ADDR_W-1:0] addr,
    output logic [KERNEL-1:0]        pad,
    output logic                     row_first,
    output logic                     row_last,
    output logic                     frame_last
);
    localparam int STEPS = IMG_WIDTH - KERNEL + 1;
    localparam int BEATS = IMG_WIDTH + KERNEL - 1;
    localparam int QW    = $clog2(STEPS + 1);
    localparam int PW    = $clog2(BEATS + 1);

    logic [QW-1:0] q;
    logic [PW-1:0] p;

    // both counters wrap to zero on the final beat, so a finished frame leaves them ready for the next
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            p <= '0;
        end else if (step) begin
            p <= row_last ? '0 : p + PW'(1);
            if (row_last) q <= frame_last ? '0 : q + QW'(1);
        end
    end

    assign row_first  = p == '0;
    assign row_last   = p == PW'(BEATS - 1);
    assign frame_last = row_last && q == QW'(STEPS - 1);

    // lane m reads image row q+m, delayed by m beats to produce the diagonal skew
    always_comb begin
        addr = '0;
        pad  = '0;
        for (int m = 0; m < KERNEL; m++) begin
            pad[m] = (32'(p) < m) || (32'(p) > IMG_WIDTH - 1 + m);
            if (!pad[m]) addr[m*ADDR_W +: ADDR_W] = ADDR_W'((m + 32'(q)) * IMG_WIDTH + 32'(p) - m);
        end
    end
endmodule

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: streams skewed, zero-padded image rows from banked memory into the PE array
//   sys_clk    in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a frame when idle
//   out_ready  in   downstream accepts a beat; low stalls both pipe stages
//   mem_en     out  read enable for all banks
//   mem_addr   out  lane m address in [m*ADDR_W +: ADDR_W]
//   mem_rdata  in   lane m data, one cycle after mem_en, held while mem_en low
//   x_out      out  lane m pixel in [m*DATA_W +: DATA_W]
//   x_valid    out  x_out carries a frame or drain beat
//   row_first  out  first beat of an output row
//   row_last   out  last beat of an output row
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last drain beat is accepted
module conv_row_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int IMG_WIDTH = cnn_pkg::IMG_WIDTH,
    parameter int KERNEL    = cnn_pkg::KERNEL,
    parameter int ADDR_W    = cnn_pkg::ADDR_W,
    parameter int DRAIN     = cnn_pkg::DRAIN_BEATS
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     mem_en,
    output logic [KERNEL*ADDR_W-1:0] mem_addr,
    input  logic [KERNEL*DATA_W-1:0] mem_rdata,
    output logic [KERNEL*DATA_W-1:0] x_out,
    output logic                     x_valid,
    output logic                     row_first,
    output logic                     row_last,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int DW = $clog2(DRAIN + 1);

    if (IMG_WIDTH < KERNEL || IMG_WIDTH * IMG_WIDTH > 2 ** ADDR_W) begin : g_bad_params
        $error("conv_row_feeder: IMG_WIDTH/KERNEL/ADDR_W combination is not legal");
    end

    feeder_state_e state, state_nx;
    logic [DW-1:0] dcnt;
    logic [KERNEL-1:0] ag_pad, b_live;
    logic [KERNEL*ADDR_W-1:0] ag_addr;
    logic run, adv, step, drain_end, ag_first, ag_last, ag_frame_last;

    assign adv       = out_ready;
    assign run       = state == S_RUN;
    assign step      = run && adv;
    // the extra DRAIN-state cycle lets the last drain beat be accepted before DONE
    assign drain_end = state == S_DRAIN && dcnt == DW'(DRAIN);

    feeder_addr_gen #(
        .IMG_WIDTH(IMG_WIDTH),
        .KERNEL   (KERNEL),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .step      (step),
        .addr      (ag_addr),
        .pad       (ag_pad),
        .row_first (ag_first),
        .row_last  (ag_last),
        .frame_last(ag_frame_last)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                busy     = 1'b1;
                mem_en   = adv;
                mem_addr = ag_addr;
                if (step && ag_frame_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (adv && drain_end) state_nx = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) dcnt <= '0;
        else if (state != S_DRAIN) dcnt <= '0;
        else if (adv) dcnt <= dcnt + DW'(1);
    end

    // stage B: flags registered alongside the bank read so they line up with mem_rdata
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid   <= 1'b0;
            b_live    <= '0;
            row_first <= 1'b0;
            row_last  <= 1'b0;
        end else if (adv) begin
            x_valid   <= run || (state == S_DRAIN && !drain_end);
            b_live    <= run ? ~ag_pad : '0;
            row_first <= run && ag_first;
            row_last  <= run && ag_last;
        end
    end

    // banks hold their data during a stall, so gating by the live mask keeps x_out frozen too
    always_comb begin
        x_out = '0;
        for (int m = 0; m < KERNEL; m++)
            if (b_live[m]) x_out[m*DATA_W +: DATA_W] = mem_rdata[m*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_conv_row_feeder.sv
// tb_conv_row_feeder: scoreboard bench for conv_row_feeder on a 5x5 image with mem[i]=i+1
module tb_conv_row_feeder;
    import cnn_pkg::*;
    localparam int DW = 8, W = 5, K = 3, AW = 5, DR = 3;
    localparam int STEPS = W - K + 1, BEATS = W + K - 1, NBEATS = STEPS * BEATS + DR;

    typedef struct packed {
        logic [K*DW-1:0] x;
        logic            first;
        logic            last;
    } beat_t;

    logic sys_clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic mem_en, x_valid, row_first, row_last, busy, frame_done;
    logic [K*AW-1:0] mem_addr;
    logic [K*DW-1:0] mem_rdata, x_out;

    int tests = 0, fails = 0, beats = 0, dones = 0, cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    beat_t sb[$];
    beat_t got[NBEATS];

    conv_row_feeder #(.DATA_W(DW), .IMG_WIDTH(W), .KERNEL(K), .ADDR_W(AW), .DRAIN(DR)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .x_out(x_out), .x_valid(x_valid), .row_first(row_first), .row_last(row_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // each bank holds the whole image, mem[i] = i+1, one-cycle read latency
    always @(posedge sys_clk)
        if (mem_en)
            for (int m = 0; m < K; m++)
                mem_rdata[m*DW +: DW] <= DW'(int'(mem_addr[m*AW +: AW]) + 1);

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [K*DW-1:0] pack3(int a, int b, int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic beat_t model(int q, int p);
        beat_t b;
        b.x = '0;
        for (int m = 0; m < K; m++)
            if (p >= m && p <= W - 1 + m) b.x[m*DW +: DW] = DW'((m + q) * W + p - m + 1);
        b.first = p == 0;
        b.last  = p == BEATS - 1;
        return b;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        for (int q = 0; q < STEPS; q++)
            for (int p = 0; p < BEATS; p++) sb.push_back(model(q, p));
        for (int d = 0; d < DR; d++) sb.push_back('0);
    endtask

    task automatic monitor();
        beat_t b;
        forever begin
            @(negedge sys_clk);
            if (frame_done) begin
                dones++;
                done_cyc = cyc;
            end
            if (rst_n && x_valid && out_ready) begin
                b = {x_out, row_first, row_last};
                if (beats < NBEATS) got[beats] = b;
                beats++;
                last_beat_cyc = cyc;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL extra_beat observed=%0h expected=none", b);
                end else check("beat", b, sb.pop_front());
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge sys_clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        check("done_seen", frame_done, 1);
    endtask

    task automatic wait_beats(int k);
        int n = 0;
        while (beats < k && n < 200) begin
            @(posedge sys_clk);
            n++;
        end
        check("beats_reached", beats >= k, 1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_x"}, {x_out, x_valid, row_first, row_last}, 0);
        check({tag, "_mem"}, {mem_en, mem_addr}, 0);
        check({tag, "_ctl"}, {busy, frame_done}, 0);
    endtask

    task automatic check_frame_end(string tag);
        repeat (3) @(posedge sys_clk);
        #1;
        check({tag, "_beats"}, beats, NBEATS);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_done_lat"}, done_cyc, last_beat_cyc + 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int idx[8]    = '{0, 1, 2, 3, 5, 6, 7, 20};
        int px[8][3]  = '{'{1,0,0}, '{2,6,0}, '{3,7,11}, '{4,8,12}, '{0,10,14}, '{0,0,15}, '{6,0,0}, '{0,0,25}};
        int pf[8]     = '{1, 0, 0, 0, 0, 0, 1, 0};
        int pl[8]     = '{0, 0, 0, 0, 0, 1, 0, 1};
        fork monitor(); join_none

        repeat (3) @(posedge sys_clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge sys_clk) #1;

        // frame 1: latency, directed beat values, counts
        beats = 0;
        dones = 0;
        push_frame();
        pulse_start();
        check("lat_mem_en", {mem_en, busy, x_valid}, 3'b110);
        check("lat_addr0", mem_addr, 0);
        @(posedge sys_clk) #1;
        check("lat_first_beat", {x_out, x_valid, row_first}, {pack3(1, 0, 0), 2'b11});
        wait_done();
        check_frame_end("f1");
        for (int i = 0; i < 8; i++)
            check("f1_directed", got[idx[i]], {pack3(px[i][0], px[i][1], px[i][2]), pf[i][0], pl[i][0]});
        for (int i = STEPS * BEATS; i < NBEATS; i++) check("f1_drain", got[i], 0);

        // frame 2: three-cycle stall while beat 5 is presented
        beats = 0;
        dones = 0;
        push_frame();
        pulse_start();
        wait_beats(4);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            check("stall_x", {x_out, x_valid}, {pack3(5, 9, 13), 1'b1});
            check("stall_mem_en", mem_en, 0);
        end
        @(posedge sys_clk) #1;
        out_ready = 1'b1;
        wait_done();
        check_frame_end("f2");

        // frame 3: start while busy, and start coinciding with frame_done, both ignored
        beats = 0;
        dones = 0;
        push_frame();
        pulse_start();
        repeat (6) @(posedge sys_clk);
        #1;
        pulse_start();
        wait_done();
        start = 1'b1;
        @(posedge sys_clk) #1;
        start = 1'b0;
        check_frame_end("f3");
        check("f3_no_restart", {busy, x_valid, mem_en}, 0);

        // frame 4: reset while beat 10 is presented, then a clean restart
        beats = 0;
        dones = 0;
        push_frame();
        pulse_start();
        wait_beats(9);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        sb.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        check("abort_no_done", dones, 0);
        rst_n = 1'b1;
        @(posedge sys_clk) #1;
        beats = 0;
        push_frame();
        pulse_start();
        @(posedge sys_clk) #1;
        check("restart_first", {x_out, x_valid, row_first}, {pack3(1, 0, 0), 2'b11});
        wait_done();
        check_frame_end("f4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
